// File: rtl/carga_operandos.sv
// Operand-load / compute stage: loads A and B from a synchronous ROM and computes C (add, sub, repeated-add multiply).
// Optional macro SIGNED_MUL_EN: treat A and B as two's complement for add, sub and multiply.
module carga_operandos #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EnA,
    input  logic                  EnB,
    input  logic                  EnC,
    input  logic [ADDR_W-1:0]     Endereco,
    input  logic                  Op,
    input  logic                  SELM,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  FimA,
    output logic                  FimB,
    output logic                  FimC,
    output logic [DATA_W-1:0]     A_q,
    output logic [DATA_W-1:0]     B_q,
    output logic [2*DATA_W-1:0]   C_q
);

    localparam int unsigned C_W = 2 * DATA_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] a_d, b_d;
    logic [C_W-1:0]    c_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              fim_a_d, fim_b_d, fim_c_d;
    logic              prev_a_q, prev_b_q, prev_c_q;
    logic              pend_a_q, pend_b_q, pend_c_q;
    logic              pend_a_d, pend_b_d, pend_c_d;

    logic              edge_a, edge_b, edge_c;
    logic              want_a, want_b, want_c;
    logic [C_W-1:0]    a_ext, b_ext, addend;
    logic [DATA_W-1:0] mul_cnt_init;
    logic              b_neg;

    // Operand extension: sign- or zero-extend to result width
`ifdef SIGNED_MUL_EN
    assign a_ext = {{DATA_W{A_q[DATA_W-1]}}, A_q};
    assign b_ext = {{DATA_W{B_q[DATA_W-1]}}, B_q};
    assign b_neg = B_q[DATA_W-1];
`else
    assign a_ext = {{DATA_W{1'b0}}, A_q};
    assign b_ext = {{DATA_W{1'b0}}, B_q};
    assign b_neg = 1'b0;
`endif

    // Negative multiplier: iterate |B| times adding -A
    assign addend       = b_neg ? (C_W'(0) - a_ext) : a_ext;
    assign mul_cnt_init = b_neg ? (DATA_W'(0) - B_q) : B_q;

    assign edge_a = EnA & ~prev_a_q;
    assign edge_b = EnB & ~prev_b_q;
    assign edge_c = EnC & ~prev_c_q;
    assign want_a = pend_a_q | edge_a;
    assign want_b = pend_b_q | edge_b;
    assign want_c = pend_c_q | edge_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            A_q      <= '0;
            B_q      <= '0;
            C_q      <= '0;
            rom_addr <= '0;
            FimA     <= 1'b0;
            FimB     <= 1'b0;
            FimC     <= 1'b0;
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
            prev_c_q <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            pend_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            A_q      <= a_d;
            B_q      <= b_d;
            C_q      <= c_d;
            rom_addr <= rom_addr_d;
            FimA     <= fim_a_d;
            FimB     <= fim_b_d;
            FimC     <= fim_c_d;
            prev_a_q <= EnA;
            prev_b_q <= EnB;
            prev_c_q <= EnC;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pend_c_q <= pend_c_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = A_q;
        b_d        = B_q;
        c_d        = C_q;
        rom_addr_d = rom_addr;
        fim_a_d    = 1'b0;
        fim_b_d    = 1'b0;
        fim_c_d    = 1'b0;
        pend_a_d   = want_a;
        pend_b_d   = want_b;
        pend_c_d   = want_c;

        case (state_q)
            S_IDLE: begin
                if (want_a) begin
                    pend_a_d   = 1'b0;
                    rom_addr_d = Endereco;
                    cnt_d      = '0;
                    state_d    = S_RD_A;
                end else if (want_b) begin
                    pend_b_d   = 1'b0;
                    rom_addr_d = Endereco;
                    cnt_d      = '0;
                    state_d    = S_RD_B;
                end else if (want_c) begin
                    pend_c_d = 1'b0;
                    if (SELM) begin
                        c_d     = '0;
                        cnt_d   = mul_cnt_init;
                        state_d = (mul_cnt_init == '0) ? S_DONE : S_MUL;
                    end else begin
                        c_d     = Op ? (a_ext - b_ext) : (a_ext + b_ext);
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_A: begin
                if (cnt_q == DATA_W'(ROM_LAT)) begin
                    a_d     = rom_data;
                    fim_a_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DATA_W'(1);
                end
            end
            S_RD_B: begin
                if (cnt_q == DATA_W'(ROM_LAT)) begin
                    b_d     = rom_data;
                    fim_b_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DATA_W'(1);
                end
            end
            S_MUL: begin
                c_d   = C_q + addend;
                cnt_d = cnt_q - DATA_W'(1);
                if (cnt_q == DATA_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fim_c_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_carga_operandos.sv
// Directed self-checking bench for carga_operandos with a one-cycle-latency synchronous ROM model.
module tb_carga_operandos;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 9;
    // Fim seen on the k-th negedge after the request is driven (accepting edge counts as 1)
    localparam int LOAD_LAT = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 EnA, EnB, EnC;
    logic [ADDR_W-1:0]    Endereco;
    logic                 Op, SELM;
    logic [ADDR_W-1:0]    rom_addr;
    logic [DATA_W-1:0]    rom_data;
    logic                 FimA, FimB, FimC;
    logic [DATA_W-1:0]    A_q, B_q;
    logic [2*DATA_W-1:0]  C_q;

    logic [DATA_W-1:0]    rom_mem [0:(1<<ADDR_W)-1];

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    logic seen;

    carga_operandos dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EnA      (EnA),
        .EnB      (EnB),
        .EnC      (EnC),
        .Endereco (Endereco),
        .Op       (Op),
        .SELM     (SELM),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .FimA     (FimA),
        .FimB     (FimB),
        .FimC     (FimC),
        .A_q      (A_q),
        .B_q      (B_q),
        .C_q      (C_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fim_sel(input int which);
        case (which)
            0:       return FimA;
            1:       return FimB;
            default: return FimC;
        endcase
    endfunction

    task automatic wait_fim(input int which, input int max_cyc, output int l);
        int i;
        l = -1;
        i = 0;
        while (l < 0 && i < max_cyc) begin
            @(negedge clk);
            i++;
            if (fim_sel(which) === 1'b1) l = i;
        end
        if (l > 0) chk("fim_exclusive", 32'(FimA) + 32'(FimB) + 32'(FimC), 32'd1);
    endtask

    task automatic load(input int which, input logic [ADDR_W-1:0] addr, input string tag);
        int l;
        @(negedge clk);
        Endereco = addr;
        if (which == 0) EnA = 1'b1; else EnB = 1'b1;
        wait_fim(which, 20, l);
        chk(tag, 32'(l), 32'(LOAD_LAT));
        EnA = 1'b0;
        EnB = 1'b0;
    endtask

    task automatic calc(input logic sel, input logic op, input int exp_lat,
                        input logic [15:0] exp_c, input string tag);
        int l;
        @(negedge clk);
        SELM = sel;
        Op   = op;
        EnC  = 1'b1;
        wait_fim(2, 400, l);
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        chk({tag, "_c"}, 32'(C_q), 32'(exp_c));
        EnC = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = '0;
        rom_mem[1]  = 8'd12;  rom_mem[2]  = 8'd5;   rom_mem[3]  = 8'd3;
        rom_mem[4]  = 8'd255; rom_mem[5]  = 8'd0;   rom_mem[6]  = 8'd7;
        rom_mem[7]  = 8'd200; rom_mem[8]  = 8'd9;
        rom_mem[10] = 8'hFD;  rom_mem[11] = 8'hFC;  rom_mem[12] = 8'd5;
        rom_mem[13] = 8'hFE;

        rst_n = 1'b0; EnA = 1'b0; EnB = 1'b0; EnC = 1'b0;
        Endereco = '0; Op = 1'b0; SELM = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_A", 32'(A_q), 32'd0);
        chk("rst_B", 32'(B_q), 32'd0);
        chk("rst_C", 32'(C_q), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_fim", {29'd0, FimA, FimB, FimC}, 32'd0);
        rst_n = 1'b1;

        // Load A, then hold EnA high: exactly one FimA
        @(negedge clk);
        Endereco = 9'd1;
        EnA = 1'b1;
        wait_fim(0, 20, lat);
        chk("loadA_lat", 32'(lat), 32'(LOAD_LAT));
        chk("loadA_addr", 32'(rom_addr), 32'd1);
        chk("loadA_val", 32'(A_q), 32'd12);
        @(negedge clk);
        chk("loadA_pulse", 32'(FimA), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (FimA) seen = 1'b1;
        end
        chk("loadA_level_once", 32'(seen), 32'd0);
        EnA = 1'b0;

        // Subtract and add
        load(0, 9'd3, "ldA3");
        load(1, 9'd2, "ldB5");
        chk("B_val", 32'(B_q), 32'd5);
        calc(1'b0, 1'b1, 2, 16'hFFFE, "sub");
        @(negedge clk);
        chk("sub_pulse", 32'(FimC), 32'd0);
        chk("A_stable", 32'(A_q), 32'd3);
        calc(1'b0, 1'b0, 2, 16'd8, "add");

        // Multiply at full scale and with zero multiplier
        load(0, 9'd4, "ldA255");
        load(1, 9'd4, "ldB255");
`ifdef SIGNED_MUL_EN
        calc(1'b1, 1'b0, 3, 16'd1, "mul255");
`else
        calc(1'b1, 1'b0, 257, 16'd65025, "mul255");
`endif
        load(0, 9'd8, "ldA9");
        load(1, 9'd5, "ldB0");
        calc(1'b1, 1'b0, 2, 16'd0, "mul_b0");

        // Simultaneous EnA+EnC: A loads first, C uses the new A (3+0)
        @(negedge clk);
        Endereco = 9'd3; SELM = 1'b0; Op = 1'b0;
        EnA = 1'b1; EnC = 1'b1;
        wait_fim(0, 20, lat);
        chk("ovl_fimA_lat", 32'(lat), 32'(LOAD_LAT));
        wait_fim(2, 20, lat);
        chk("ovl_fimC_lat", 32'(lat), 32'd2);
        chk("ovl_c", 32'(C_q), 32'd3);
        EnA = 1'b0; EnC = 1'b0;

        // EnB edge during MUL (3*7) is served right after FimC
        load(1, 9'd6, "ldB7");
        @(negedge clk);
        SELM = 1'b1;
        EnC = 1'b1;
        repeat (3) @(negedge clk);
        Endereco = 9'd2;
        EnB = 1'b1;
        wait_fim(2, 40, lat);
        chk("mulB_fimC_lat", 32'(lat), 32'd6);
        chk("mulB_c", 32'(C_q), 32'd21);
        wait_fim(1, 20, lat);
        chk("mulB_fimB_lat", 32'(lat), 32'd3);
        chk("mulB_b", 32'(B_q), 32'd5);
        chk("mulB_c_stable", 32'(C_q), 32'd21);
        EnB = 1'b0; EnC = 1'b0;

`ifdef SIGNED_MUL_EN
        load(0, 9'd10, "ldAm3");
        load(1, 9'd11, "ldBm4");
        calc(1'b1, 1'b0, 6, 16'd12, "smul_neg_neg");
        calc(1'b0, 1'b0, 2, 16'hFFF9, "sadd");
        load(0, 9'd12, "ldA5");
        load(1, 9'd13, "ldBm2");
        calc(1'b1, 1'b0, 4, 16'hFFF6, "smul_pos_neg");
`endif

        // Reset in the middle of a 7*200 multiply
        load(0, 9'd6, "ldA7");
        load(1, 9'd7, "ldB200");
        @(negedge clk);
        SELM = 1'b1;
        EnC = 1'b1;
        repeat (10) @(negedge clk);
        chk("midmul_nofim", 32'(FimC), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_A", 32'(A_q), 32'd0);
        chk("midrst_B", 32'(B_q), 32'd0);
        chk("midrst_C", 32'(C_q), 32'd0);
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        chk("midrst_fim", {29'd0, FimA, FimB, FimC}, 32'd0);
        EnC = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (FimA || FimB || FimC) seen = 1'b1;
        end
        chk("postrst_no_fim", 32'(seen), 32'd0);
        chk("postrst_C", 32'(C_q), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/carga_operandos.md
Name: carga_operandos

Overview:
- Datapath stage directly downstream of the sequencing controller.
- Consumes the controller's `EnA`/`EnB`/`EnC`, `Endereco`, `Op` and `SELM`. Reads operands from the synchronous operand ROM, loads registers A and B, and computes result C (add, sub, or multiply by repeated addition).
- Returns one-cycle `FimA`/`FimB`/`FimC` completion pulses to the controller.
- Runs on posedge; the controller samples the `Fim*` pulses on the following negedge.

Parameters:
- DATA_W, 8: width of ROM words and of operand registers A and B.
- ADDR_W, 9: width of `Endereco` and `rom_addr`.
- ROM_LAT, 1: ROM read latency in clocks, from `rom_addr` driven to `rom_data` valid. Legal range 1..3.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- EnA  in  1  request: load A from ROM[Endereco].
- EnB  in  1  request: load B from ROM[Endereco].
- EnC  in  1  request: compute C from A and B.
- Endereco  in  ADDR_W  ROM address, sampled when a load request is accepted.
- Op  in  1  operation when SELM=0: 0 = add, 1 = subtract (A-B).
- SELM  in  1  1 = multiply (Op ignored).
- rom_addr  out  ADDR_W  address to ROM.
- rom_data  in  DATA_W  ROM read data.
- FimA  out  1  one-cycle pulse: A loaded.
- FimB  out  1  one-cycle pulse: B loaded.
- FimC  out  1  one-cycle pulse: C valid.
- A_q  out  DATA_W  register A.
- B_q  out  DATA_W  register B.
- C_q  out  2*DATA_W  result register.

Behaviour:
- Reset (async, any state, including mid-multiply):
  - State goes to IDLE.
  - Cleared to 0: `A_q`, `B_q`, `C_q`, `rom_addr`, `Fim*`, iteration counter, previous-enable registers.
- Request detection: each of `EnA`/`EnB`/`EnC` is registered. A request is a rising edge (current 1, previous 0), so a level held high is served exactly once.
- Accepting requests:
  - Requests are accepted only in IDLE.
  - An edge arriving while busy is held pending (one sticky bit per enable) and served on return to IDLE.
  - Priority when several requests are pending or simultaneous: A > B > C.
- State machine: IDLE, RD_A, RD_B, MUL, DONE.
- IDLE:
  - Pending A: `rom_addr`<=`Endereco`, go to RD_A.
  - Else pending B: `rom_addr`<=`Endereco`, go to RD_B.
  - Else pending C: see the C computation rules below.
- RD_A / RD_B:
  - Wait ROM_LAT cycles, then capture `rom_data` into A or B.
  - Assert `FimA`/`FimB` for exactly one cycle in the capture cycle, then go to IDLE.
  - Load latency from the accepted edge is ROM_LAT+1 clocks.
- C computation, SELM=0:
  - Computed in IDLE at acceptance.
  - `C_q` <= zero-extended A + B (Op=0) or A - B (Op=1), taken modulo 2^(2*DATA_W).
  - `FimC` pulses on the next cycle (DONE). Latency 2.
  - Example: 3-5 gives 16'hFFFE.
- C computation, SELM=1:
  - On acceptance: `C_q`<=0, counter<=B, go to MUL.
  - In MUL: each cycle `C_q`<=`C_q`+A and counter decrements. Leave MUL when the counter reaches 0 and go to DONE, which pulses `FimC`.
  - If B=0: skip MUL and go directly to DONE (`C_q`=0). Latency 2.
  - Otherwise latency is B+2. Maximum 255*255 = 65025 fits in 16 bits; there is no overflow.
- DONE: `FimC`=1 for one cycle, then IDLE.
- Register stability: A and B change only on their own capture; C changes only during computation.
- Address: `rom_addr` holds its last value between reads.
- Outputs: `Fim*` are registered and never asserted simultaneously.

Optional Feature:
- Macro: `SIGNED_MUL_EN`.
- Defined:
  - A and B are two's complement; add and sub sign-extend both operands to 2*DATA_W.
  - Multiply: if B<0, the counter loads -B and each iteration adds -A (sign-extended), giving the signed product.
  - B=-128 runs 128 iterations.
- Undefined: all operands are unsigned and zero-extended, as described in Behaviour.

Test Plan:
- Reset check: reset asserted mid-MUL (A=7, B=200, after 10 cycles) -> all outputs 0 immediately; state IDLE; no `FimC` after release.
- Load A: ROM[1]=8'd12, `EnA` rise with `Endereco`=1, ROM_LAT=1 -> `rom_addr`=1, `A_q`=12 with a `FimA` pulse 2 clocks after the edge; `EnA` held high 5 more cycles -> no second `FimA`.
- Load B and subtract: A=3, ROM[2]=5, `EnB` rise, then `EnC` with Op=1, SELM=0 -> `B_q`=5; `C_q`=16'hFFFE, one-cycle `FimC`. Repeat with Op=0 -> 16'd8.
- Multiply: A=255, B=255, SELM=1 -> `FimC` 257 clocks after the `EnC` edge, `C_q`=16'd65025. A=9, B=0 -> `FimC` after 2 clocks, `C_q`=0.
- Overlap: `EnA` and `EnC` rise in the same cycle -> A loaded first (`FimA`), then C computed with the new A (`FimC`). An `EnB` edge during MUL is served right after `FimC`.
- With `SIGNED_MUL_EN`: A=8'hFD (-3), B=8'hFC (-4), SELM=1 -> `C_q`=16'd12. A=5, B=-2 -> `C_q`=16'hFFF6.
